// File: rtl/m_uart_wbmaster_pkg.sv
// Shared definitions for the UART-to-Wishbone debug bridge.
//   - command / reply byte constants seen on the serial link
//   - state encodings for the command FSM and the RX byte sampler
package m_uart_wbmaster_pkg;

    localparam logic [7:0] CMD_W   = 8'h57;  // 'W' + A0..A3 + D0..D3
    localparam logic [7:0] CMD_R   = 8'h52;  // 'R' + A0..A3
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K' write completed
    localparam logic [7:0] RSP_BAD = 8'h3F;  // '?' unknown command byte
    localparam logic [7:0] RSP_TO  = 8'h21;  // '!' bus cycle timed out

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_BUS,
        ST_REPLY
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/m_uart_rx8.sv
// 8N1 UART byte receiver.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   rx         : asynchronous serial input, idle high
//   byte_valid : one-clock strobe when a byte with a valid stop bit arrives
//   byte_data  : received byte, valid while byte_valid is high
// A falling edge starts a frame; the start bit is re-checked half a bit later
// so short low glitches are rejected. Frames with a low stop bit are dropped.
module m_uart_rx8 #(
    parameter int DIVISOR = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data
);
    import m_uart_wbmaster_pkg::*;

    localparam logic [15:0] DIV_M1  = 16'(DIVISOR - 1);
    localparam logic [15:0] HALF_M1 = 16'(DIVISOR / 2 - 1);

    rx_state_e   st_q, st_d;
    logic [2:0]  sync_q, sync_d;   // [1:0] synchroniser, [2] previous synchronised level
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shr_q, shr_d;
    logic        vld_q, vld_d;
    logic        cur;

    assign cur        = sync_q[1];
    assign byte_valid = vld_q;
    assign byte_data  = shr_q;

    always_comb begin
        st_d   = st_q;
        sync_d = {sync_q[1:0], rx};
        cnt_d  = cnt_q + 16'd1;
        bit_d  = bit_q;
        shr_d  = shr_q;
        vld_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (sync_q[2] && !cur) st_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_M1) begin
                cnt_d = '0;
                bit_d = '0;
                st_d  = cur ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == DIV_M1) begin
                cnt_d = '0;
                shr_d = {cur, shr_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) st_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == DIV_M1) begin
                // Back to idle mid-stop-bit so the next start edge is caught.
                vld_d = cur;
                st_d  = RX_IDLE;
            end
            default: st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= RX_IDLE;
            sync_q <= 3'b111;
            cnt_q  <= '0;
            bit_q  <= '0;
            shr_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            shr_q  <= shr_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: rtl/m_uart_wbmaster.sv
// UART debug/loader bridge acting as a Wishbone classic bus initiator.
//   CLK_I, RST_I     : clock, synchronous active-high reset
//   usartRX/usartTX  : 8N1 serial link, idle high
//   bus_req/bus_gnt  : ownership handshake with the slave-bus arbiter
//   CYC_O..SEL_O     : Wishbone master outputs (single 32-bit cycles)
//   ACK_I, DAT_I     : Wishbone slave response
// Commands: 'W' A0..A3 D0..D3 -> write, reply 'K'; 'R' A0..A3 -> read, reply
// D0..D3 LSB first; anything else -> '?'.
// Optional macro UARTWB_ACKTIMEOUT_EN: abort a bus cycle with no ACK_I after
// 255 clocks and reply '!'.
module m_uart_wbmaster #(
    parameter int DIVISOR = 104,
    parameter int GAPBITS = 32
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        usartRX,
    output logic        usartTX,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    input  logic        ACK_I,
    input  logic [31:0] DAT_I
);
    import m_uart_wbmaster_pkg::*;

    localparam logic [15:0] DIV_M1 = 16'(DIVISOR - 1);
    localparam logic [31:0] GAP_M1 = 32'(GAPBITS * DIVISOR - 1);

    logic       rx_vld;
    logic [7:0] rx_byte;

    m_uart_rx8 #(.DIVISOR(DIVISOR)) u_rx (
        .clk        (CLK_I),
        .rst        (RST_I),
        .rx         (usartRX),
        .byte_valid (rx_vld),
        .byte_data  (rx_byte)
    );

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rsp_q, rsp_d;       // reply bytes, sent from the low end
    logic [2:0]  rleft_q, rleft_d;   // reply bytes still to hand to TX
    logic        req_q, req_d;
    logic        cyc_q, cyc_d;
    logic [31:0] gap_q, gap_d;
`ifdef UARTWB_ACKTIMEOUT_EN
    logic [7:0]  to_q, to_d;
`endif

    logic [9:0]  tx_sh_q, tx_sh_d;
    logic [3:0]  tx_bits_q, tx_bits_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic        tx_load, tx_ready;
    logic [7:0]  tx_byte;

    // Ready in the last clock of the stop bit so consecutive bytes abut.
    assign tx_ready = (tx_bits_q == 4'd0) || (tx_bits_q == 4'd1 && tx_cnt_q == DIV_M1);

    assign usartTX = (tx_bits_q == 4'd0) ? 1'b1 : tx_sh_q[0];
    assign bus_req = req_q;
    assign CYC_O   = cyc_q;
    assign STB_O   = cyc_q;
    assign WE_O    = cyc_q & is_wr_q;
    assign ADR_O   = adr_q;
    assign DAT_O   = dat_q;
    assign SEL_O   = {4{cyc_q}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rsp_d   = rsp_q;
        rleft_d = rleft_q;
        req_d   = req_q;
        cyc_d   = cyc_q;
        gap_d   = '0;
        tx_load = 1'b0;
        tx_byte = rsp_q[7:0];
`ifdef UARTWB_ACKTIMEOUT_EN
        to_d    = '0;
`endif
        case (state_q)
            ST_IDLE: if (rx_vld) begin
                cnt_d = '0;
                if (rx_byte == CMD_W || rx_byte == CMD_R) begin
                    is_wr_d = (rx_byte == CMD_W);
                    state_d = ST_ADDR;
                end else begin
                    rsp_d   = {24'h0, RSP_BAD};
                    rleft_d = 3'd1;
                    state_d = ST_REPLY;
                end
            end
            ST_ADDR, ST_DATA: begin
                gap_d = gap_q + 32'd1;
                if (rx_vld) begin
                    gap_d = '0;
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == ST_ADDR) adr_d = {rx_byte, adr_q[31:8]};
                    else                    dat_d = {rx_byte, dat_q[31:8]};
                    if (cnt_q == 2'd3) begin
                        if (state_q == ST_ADDR && is_wr_q) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_REQ;
                            req_d   = 1'b1;
                        end
                    end
                end else if (gap_q == GAP_M1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: if (bus_gnt) begin
                cyc_d   = 1'b1;
                state_d = ST_BUS;
            end
            ST_BUS: begin
                if (ACK_I) begin
                    cyc_d   = 1'b0;
                    req_d   = 1'b0;
                    state_d = ST_REPLY;
                    if (is_wr_q) begin
                        rsp_d   = {24'h0, RSP_OK};
                        rleft_d = 3'd1;
                    end else begin
                        rsp_d   = DAT_I;
                        rleft_d = 3'd4;
                    end
                end
`ifdef UARTWB_ACKTIMEOUT_EN
                // to_q counts clocks already spent with CYC_O high.
                else if (to_q == 8'd254) begin
                    cyc_d   = 1'b0;
                    req_d   = 1'b0;
                    rsp_d   = {24'h0, RSP_TO};
                    rleft_d = 3'd1;
                    state_d = ST_REPLY;
                end else begin
                    to_d = to_q + 8'd1;
                end
`endif
            end
            ST_REPLY: if (tx_ready) begin
                tx_load = 1'b1;
                rsp_d   = {8'h00, rsp_q[31:8]};
                rleft_d = rleft_q - 3'd1;
                if (rleft_q == 3'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_sh_d   = tx_sh_q;
        tx_bits_d = tx_bits_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_bits_q != 4'd0) begin
            if (tx_cnt_q == DIV_M1) begin
                tx_cnt_d  = '0;
                tx_sh_d   = {1'b1, tx_sh_q[9:1]};
                tx_bits_d = tx_bits_q - 4'd1;
            end else begin
                tx_cnt_d  = tx_cnt_q + 16'd1;
            end
        end
        if (tx_load) begin
            tx_sh_d   = {1'b1, tx_byte, 1'b0};
            tx_bits_d = 4'd10;
            tx_cnt_d  = '0;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_wr_q   <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_q     <= '0;
            rleft_q   <= '0;
            req_q     <= 1'b0;
            cyc_q     <= 1'b0;
            gap_q     <= '0;
            tx_sh_q   <= '1;
            tx_bits_q <= '0;
            tx_cnt_q  <= '0;
`ifdef UARTWB_ACKTIMEOUT_EN
            to_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_q     <= rsp_d;
            rleft_q   <= rleft_d;
            req_q     <= req_d;
            cyc_q     <= cyc_d;
            gap_q     <= gap_d;
            tx_sh_q   <= tx_sh_d;
            tx_bits_q <= tx_bits_d;
            tx_cnt_q  <= tx_cnt_d;
`ifdef UARTWB_ACKTIMEOUT_EN
            to_q      <= to_d;
`endif
        end
    end

endmodule

// File: tb/tb_m_uart_wbmaster.sv
module tb_m_uart_wbmaster;
    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        RST_I = 1'b1;
    logic        usartRX = 1'b1;
    logic        usartTX, bus_req, bus_gnt, CYC_O, STB_O, WE_O;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic        ACK_I = 1'b0;
    logic [31:0] DAT_I = '0;

    always #5 clk = ~clk;

    m_uart_wbmaster #(.DIVISOR(DIV), .GAPBITS(32)) dut (
        .CLK_I(clk), .RST_I(RST_I), .usartRX(usartRX), .usartTX(usartTX),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .CYC_O(CYC_O), .STB_O(STB_O),
        .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
        .ACK_I(ACK_I), .DAT_I(DAT_I)
    );

    int checks = 0;
    int errors = 0;

    // arbiter: follows bus_req, or a manual level
    bit gnt_auto = 1'b1;
    bit gnt_man  = 1'b0;
    assign bus_gnt = gnt_auto ? bus_req : gnt_man;

    // Wishbone responder state
    bit          resp_en = 1'b1;
    int          ack_dly = 1;
    logic [31:0] rd_data = '0;
    int          cyc_cnt = 0, stab_err = 0, wcnt = 0;
    int          force_req = 0, force_done = 0;
    logic [31:0] s_adr, s_dat;
    logic [3:0]  s_sel;
    logic        s_we, we_any, we_all;

    // serial monitor state
    bit         mon_en = 1'b0;
    logic [7:0] rx_q[$];
    int         fr_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (ACK_I) begin
                ACK_I = 1'b0;
                wcnt  = 0;
            end else if (force_req != force_done) begin
                ACK_I = 1'b1;
                DAT_I = 32'hDEAD_0000;
                force_done++;
            end else if (CYC_O && STB_O && resp_en) begin
                if (wcnt == 0) begin
                    cyc_cnt++;
                    s_adr = ADR_O; s_dat = DAT_O; s_sel = SEL_O; s_we = WE_O;
                    we_any = WE_O; we_all = WE_O;
                end else if (ADR_O !== s_adr || DAT_O !== s_dat || SEL_O !== s_sel || WE_O !== s_we) begin
                    stab_err++;
                end
                we_any = we_any | WE_O;
                we_all = we_all & WE_O;
                wcnt++;
                if (wcnt >= ack_dly) begin
                    ACK_I = 1'b1;
                    DAT_I = rd_data;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        logic [7:0] b;
        wait (mon_en);
        forever begin
            @(negedge usartTX);
            repeat (DIV / 2) @(negedge clk);
            if (usartTX == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = usartTX;
                end
                repeat (DIV) @(negedge clk);
                if (usartTX !== 1'b1) fr_err++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        usartRX = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            usartRX = b[i];
            repeat (DIV) @(negedge clk);
        end
        usartRX = stop;
        repeat (DIV) @(negedge clk);
        usartRX = 1'b1;
    endtask

    task automatic wait_rsp(input int base, input int n);
        int t = 0;
        while (rx_q.size() < base + n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (100) @(negedge clk);
    endtask

    task automatic chk_rsp(input string nm, input int base, input logic [31:0] rsp, input int n);
        chk({nm, ".rsp_len"}, rx_q.size() - base, n);
        for (int j = 0; j < n; j++)
            if (base + j < rx_q.size())
                chk($sformatf("%s.rsp%0d", nm, j), {24'h0, rx_q[base + j]}, {24'h0, rsp[31 - 8*j -: 8]});
    endtask

    task automatic wait_cyc(input string nm);
        int t = 0;
        while (!CYC_O && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, ".cyc_start"}, CYC_O, 1);
    endtask

    typedef struct packed {
        logic [71:0] cmd;      // command bytes, first byte in the top byte
        logic [3:0]  ncmd;
        logic [3:0]  ack_dly;
        logic [31:0] rdata;
        logic        exp_cyc;
        logic        exp_we;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic [31:0] rsp;      // expected reply, first byte in the top byte
        logic [2:0]  nrsp;
    } vec_t;

    task automatic run_vec(input string nm, input vec_t v);
        int base, c0, s0;
        base = rx_q.size(); c0 = cyc_cnt; s0 = stab_err;
        ack_dly = int'(v.ack_dly);
        rd_data = v.rdata;
        for (int i = 0; i < int'(v.ncmd); i++) send_byte(v.cmd[71 - 8*i -: 8], 1'b1);
        wait_rsp(base, int'(v.nrsp));
        chk({nm, ".cycles"}, cyc_cnt - c0, {31'h0, v.exp_cyc});
        if (v.exp_cyc) begin
            chk({nm, ".adr"}, s_adr, v.exp_adr);
            chk({nm, ".sel"}, {28'h0, s_sel}, 32'hF);
            chk({nm, ".we"}, {31'h0, v.exp_we ? we_all : we_any}, {31'h0, v.exp_we});
            chk({nm, ".stable"}, stab_err - s0, 0);
            if (v.exp_we) chk({nm, ".dat"}, s_dat, v.exp_dat);
        end
        chk_rsp(nm, base, v.rsp, int'(v.nrsp));
    endtask

    vec_t vecs[5];

    initial begin
        int base, c0, viol, n;
        vec_t v;

        vecs[0] = '{cmd: 72'h57_04_00_00_60_0F_00_00_00, ncmd: 9, ack_dly: 1, rdata: 32'h0,
                    exp_cyc: 1, exp_we: 1, exp_adr: 32'h6000_0004, exp_dat: 32'h0000_000F,
                    rsp: 32'h4B00_0000, nrsp: 1};
        vecs[1] = '{cmd: 72'h52_08_00_00_60_00_00_00_00, ncmd: 5, ack_dly: 3, rdata: 32'h0000_0100,
                    exp_cyc: 1, exp_we: 0, exp_adr: 32'h6000_0008, exp_dat: 32'h0,
                    rsp: 32'h00_01_00_00, nrsp: 4};
        vecs[2] = '{cmd: 72'hAA_00_00_00_00_00_00_00_00, ncmd: 1, ack_dly: 1, rdata: 32'h0,
                    exp_cyc: 0, exp_we: 0, exp_adr: 32'h0, exp_dat: 32'h0,
                    rsp: 32'h3F00_0000, nrsp: 1};
        vecs[3] = '{cmd: 72'h57_78_56_34_12_EF_BE_AD_DE, ncmd: 9, ack_dly: 5, rdata: 32'h0,
                    exp_cyc: 1, exp_we: 1, exp_adr: 32'h1234_5678, exp_dat: 32'hDEAD_BEEF,
                    rsp: 32'h4B00_0000, nrsp: 1};
        vecs[4] = '{cmd: 72'h52_FC_FF_FF_FF_00_00_00_00, ncmd: 5, ack_dly: 1, rdata: 32'hA5C3_0F81,
                    exp_cyc: 1, exp_we: 0, exp_adr: 32'hFFFF_FFFC, exp_dat: 32'h0,
                    rsp: 32'h810F_C3A5, nrsp: 4};

        // reset values
        repeat (3) @(negedge clk);
        chk("reset.tx", usartTX, 1);
        chk("reset.req", bus_req, 0);
        chk("reset.cyc_stb_we", {29'h0, CYC_O, STB_O, WE_O}, 0);
        chk("reset.adr", ADR_O, 0);
        chk("reset.dat", DAT_O, 0);
        chk("reset.sel", {28'h0, SEL_O}, 0);
        RST_I = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 5; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

        // grant withheld for 50 clocks, then removed while the cycle is open
        gnt_auto = 1'b0; gnt_man = 1'b0;
        base = rx_q.size(); c0 = cyc_cnt; ack_dly = 2; rd_data = 32'h0BAD_F00D;
        send_byte(8'h52, 1); send_byte(8'h10, 1); send_byte(8'h00, 1);
        send_byte(8'h00, 1); send_byte(8'h00, 1);
        n = 0;
        while (!bus_req && n < 200) begin @(negedge clk); n++; end
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (CYC_O || !bus_req) viol++;
        end
        chk("gnt.hold_viol", viol, 0);
        gnt_man = 1'b1;
        @(negedge clk);
        chk("gnt.cyc_1clk", CYC_O, 1);
        gnt_man = 1'b0;
        wait_rsp(base, 4);
        chk("gnt.cycles", cyc_cnt - c0, 1);
        chk("gnt.adr", s_adr, 32'h0000_0010);
        chk_rsp("gnt", base, 32'h0DF0_AD0B, 4);
        gnt_auto = 1'b1;

        // partial command abandoned by gap timeout
        base = rx_q.size(); c0 = cyc_cnt;
        send_byte(8'h57, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
        repeat (40 * DIV) @(negedge clk);
        chk("gap.no_reply", rx_q.size() - base, 0);
        chk("gap.no_cycle", cyc_cnt - c0, 0);
        v = '{cmd: 72'h52_00_00_00_00_00_00_00_00, ncmd: 5, ack_dly: 2, rdata: 32'h1357_9BDF,
              exp_cyc: 1, exp_we: 0, exp_adr: 32'h0, exp_dat: 32'h0,
              rsp: 32'hDF9B_5713, nrsp: 4};
        run_vec("gap_next", v);

        // framing error followed by a short start-bit glitch
        base = rx_q.size(); c0 = cyc_cnt;
        send_byte(8'hAA, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        usartRX = 1'b0;
        repeat (2) @(negedge clk);
        usartRX = 1'b1;
        repeat (30 * DIV) @(negedge clk);
        chk("frame.no_reply", rx_q.size() - base, 0);
        chk("frame.no_cycle", cyc_cnt - c0, 0);
        run_vec("frame_next", vecs[2]);

        // reset in the middle of a bus cycle; a late ACK_I must be ignored
        base = rx_q.size(); ack_dly = 40;
        send_byte(8'h57, 1);
        for (int i = 0; i < 8; i++) send_byte(8'h01, 1);
        wait_cyc("rst");
        repeat (3) @(negedge clk);
        RST_I = 1'b1;
        @(negedge clk);
        chk("rst.cyc_drop", {30'h0, CYC_O, STB_O}, 0);
        chk("rst.req_drop", bus_req, 0);
        RST_I = 1'b0;
        repeat (2) @(negedge clk);
        force_req++;
        repeat (30 * DIV) @(negedge clk);
        chk("rst.no_reply", rx_q.size() - base, 0);
        chk("rst.idle_bus", {30'h0, CYC_O, bus_req}, 0);
        run_vec("rst_next", vecs[0]);

`ifdef UARTWB_ACKTIMEOUT_EN
        // no ACK_I at all: cycle aborted after 255 clocks, reply '!'
        resp_en = 1'b0;
        base = rx_q.size();
        send_byte(8'h57, 1);
        for (int i = 0; i < 8; i++) send_byte(8'h02, 1);
        wait_cyc("tmo");
        n = 0;
        while (CYC_O && n < 400) begin @(negedge clk); n++; end
        chk("tmo.cyc_clocks", n, 255);
        chk("tmo.req_drop", bus_req, 0);
        wait_rsp(base, 1);
        chk_rsp("tmo", base, 32'h2100_0000, 1);
        resp_en = 1'b1;
`endif

        chk("tx.stop_bits", fr_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
